// File: rtl/rom_writer_if.sv
// Host-side request/response bundle for the EEPROM word writer.
// The loader drives the request fields; the writer answers with ready,
// the done/err completion pulses and the busy flag.
interface rom_writer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        input  wr_ready, done, err, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        output wr_ready, done, err, busy
    );
endinterface

// File: rtl/rom_writer.sv
// Byte-write programmer for the four byte-lane AT28C256 EEPROMs behind the
// instruction fetch path. One accepted 32-bit word becomes one parallel
// byte-write cycle on every enabled lane. Completion is found by DATA polling
// on DQ7 of each enabled lane, bounded by a cycle-count timeout.
// All outputs are registered and updated together with the state register.
module rom_writer #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int POLL_GAP  = 2,
    parameter int TIMEOUT   = 20000
) (
    input  logic               clk,
    input  logic               rst_flag,
    rom_writer_if.slave        bus,
    output logic [59:0]        rom_addr,
    output logic [3:0]         rom_ce,
    output logic               rom_oe,
    output logic               rom_we,
    output logic [31:0]        dq_out,
    output logic               dq_oe,
    input  logic [31:0]        dq_in
);

    localparam int CW = 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(POLL_GAP - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_POLL  = 3'd4,
        ST_RECOV = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [TW-1:0]   tmo_r;
    logic [31:0]     data_r;
    logic [3:0]      be_r;

    logic            wr_ready_r;
    logic            done_r;
    logic            err_r;
    logic            busy_r;
    logic [59:0]     rom_addr_r;
    logic [3:0]      rom_ce_r;
    logic            rom_oe_r;
    logic            rom_we_r;
    logic [31:0]     dq_out_r;
    logic            dq_oe_r;

    logic            poll_ok_s;

    // DATA polling: each enabled lane must echo the true DQ7 of the byte
    // being programmed; disabled lanes never block completion.
    function automatic logic dq7_match(input logic [31:0] rd,
                                       input logic [31:0] wd,
                                       input logic [3:0]  be);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (be[i] && (rd[8*i+7] != wd[8*i+7])) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Evaluate the poll result for the current read-back.
    always_comb begin
        poll_ok_s = 1'b0;
        poll_ok_s = dq7_match(dq_in, data_r, be_r);
    end

    // Write sequencer: state, counters, latched request and all pin outputs.
    always_ff @(posedge clk) begin
        if (!rst_flag) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            tmo_r      <= '0;
            data_r     <= 32'h0000_0000;
            be_r       <= 4'h0;
            wr_ready_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            rom_addr_r <= 60'h0;
            rom_ce_r   <= 4'hF;
            rom_oe_r   <= 1'b1;
            rom_we_r   <= 1'b1;
            dq_out_r   <= 32'h0000_0000;
            dq_oe_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wr_ready_r <= 1'b1;
                    if (bus.wr_valid && wr_ready_r) begin
                        wr_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        data_r     <= bus.wr_data;
                        be_r       <= bus.wr_be;
                        dq_out_r   <= bus.wr_data;
                        rom_addr_r <= {bus.wr_addr, 2'd3, bus.wr_addr, 2'd2,
                                       bus.wr_addr, 2'd1, bus.wr_addr, 2'd0};
                        cnt_r      <= '0;
                        tmo_r      <= '0;
                        if (bus.wr_be == 4'h0) begin
                            // Nothing to program: report completion at once.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r  <= ST_SETUP;
                            rom_ce_r <= ~bus.wr_be;
                            dq_oe_r  <= 1'b1;
                            rom_we_r <= 1'b1;
                            rom_oe_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r    <= '0;
                        state_r  <= ST_PULSE;
                        rom_we_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end

                ST_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        cnt_r    <= '0;
                        state_r  <= ST_HOLD;
                        rom_we_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end

                ST_HOLD: begin
                    // Release the bus before turning the chips around for reads.
                    state_r  <= ST_POLL;
                    dq_oe_r  <= 1'b0;
                    rom_oe_r <= 1'b0;
                    cnt_r    <= '0;
                    tmo_r    <= '0;
                end

                ST_POLL: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= '0;
                        if (poll_ok_s) begin
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
                            rom_ce_r <= 4'hF;
                            rom_oe_r <= 1'b1;
                        end else if (tmo_r == TMO_LAST) begin
                            state_r  <= ST_ERR;
                            err_r    <= 1'b1;
                            rom_ce_r <= 4'hF;
                            rom_oe_r <= 1'b1;
                        end else begin
                            // Deassert oe for one cycle so the next read is a fresh access.
                            state_r  <= ST_RECOV;
                            rom_oe_r <= 1'b1;
                            tmo_r    <= tmo_r + TW'(1);
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        cnt_r    <= '0;
                        state_r  <= ST_ERR;
                        err_r    <= 1'b1;
                        rom_ce_r <= 4'hF;
                        rom_oe_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        tmo_r <= tmo_r + TW'(1);
                    end
                end

                ST_RECOV: begin
                    if (tmo_r == TMO_LAST) begin
                        state_r  <= ST_ERR;
                        err_r    <= 1'b1;
                        rom_ce_r <= 4'hF;
                        rom_oe_r <= 1'b1;
                    end else begin
                        state_r  <= ST_POLL;
                        rom_oe_r <= 1'b0;
                        tmo_r    <= tmo_r + TW'(1);
                    end
                end

                ST_DONE, ST_ERR: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b1;
                    rom_ce_r   <= 4'hF;
                    rom_oe_r   <= 1'b1;
                    rom_we_r   <= 1'b1;
                    dq_oe_r    <= 1'b0;
                end

                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b0;
                    rom_ce_r   <= 4'hF;
                    rom_oe_r   <= 1'b1;
                    rom_we_r   <= 1'b1;
                    dq_oe_r    <= 1'b0;
                    cnt_r      <= '0;
                    tmo_r      <= '0;
                end
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
    assign bus.busy     = busy_r;
    assign rom_addr     = rom_addr_r;
    assign rom_ce       = rom_ce_r;
    assign rom_oe       = rom_oe_r;
    assign rom_we       = rom_we_r;
    assign dq_out       = dq_out_r;
    assign dq_oe        = dq_oe_r;

endmodule

// File: doc/rom_writer.md
Name: rom_writer

Overview:
- Programs 32-bit instruction words into the four byte-lane AT28C256 EEPROMs that the fetch stage reads; it is the write side of that same memory array.
- Sits between a host/loader (boot loader or debug UART bridge) and the shared EEPROM control and data pins.
- Each accepted word is written as a single byte-write cycle across all enabled lanes in parallel.
- Completion is detected by DATA polling (DQ7), with a cycle-count timeout.

Parameters:
- SETUP_CYC, 2, cycles that address and data are stable with we low inactive before the WE pulse (minimum 1).
- PULSE_CYC, 4, cycles that we is asserted (minimum 1).
- POLL_GAP, 2, cycles that oe is asserted before dq_in is sampled in each poll (minimum 1).
- TIMEOUT, 20000, maximum cycles from the end of HOLD to a successful poll before an error is reported (10 ms at 2 MHz).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_flag  in  1  synchronous reset, ACTIVE LOW.
- wr_valid  in  1  host request valid.
- wr_ready  out  1  writer can accept a request.
- wr_addr  in  13  word address (the same field as pc[14:2]).
- wr_data  in  32  word to write; byte i goes to chip i.
- wr_be  in  4  lane enables, ACTIVE HIGH.
- done  out  1  one-cycle pulse: write verified.
- err  out  1  one-cycle pulse: timeout.
- busy  out  1  high from accept until the done/err pulse inclusive.
- rom_addr  out  60  four 15-bit addresses; lane i = {word, i[1:0]}.
- rom_ce  out  4  chip enables, ACTIVE LOW.
- rom_oe  out  1  shared output enable, ACTIVE LOW.
- rom_we  out  1  shared write enable, ACTIVE LOW.
- dq_out  out  32  data driven to the chips.
- dq_oe  out  1  drive dq_out onto the bus, ACTIVE HIGH.
- dq_in  in  32  data read back from the chips.

Behaviour:
- Reset (rst_flag low at a clk edge), forcing state IDLE:
  - rom_ce=4'hF, rom_oe=1, rom_we=1, dq_oe=0.
  - done=0, err=0, busy=0, wr_ready=0 while reset is held.
  - rom_addr=0, dq_out=0.
  - All counters cleared.
  - Reset takes priority in every state, including mid-PULSE; we deasserts on the next edge.
- IDLE:
  - wr_ready=1.
  - On wr_valid & wr_ready, latch addr/data/be and go to SETUP next cycle.
  - A request with wr_be=0 is accepted and completes as done after exactly one cycle; no chip is touched.
- SETUP (SETUP_CYC cycles):
  - rom_ce[i] = ~be[i].
  - dq_oe=1, rom_we=1, rom_oe=1.
- PULSE (PULSE_CYC cycles): rom_we=0; all other outputs unchanged.
- HOLD (1 cycle): rom_we=1, dq_oe=1.
- POLL:
  - dq_oe=0, rom_oe=0 for POLL_GAP cycles.
  - Sample dq_in on the last cycle of each poll.
  - Success when, for every enabled lane i, dq_in[8i+7] equals the latched data bit [8i+7]. Disabled lanes are ignored.
  - On a failed sample: rom_oe=1 for 1 cycle, then poll again.
- Timeout counter:
  - Starts at 0 on entry to POLL and increments every POLL cycle.
  - Reaching TIMEOUT goes to ERR.
  - If success and timeout occur on the same cycle, success wins.
- DONE / ERR (1 cycle each):
  - done=1 or err=1; rom_ce=4'hF, rom_oe=1.
  - Next state IDLE; wr_ready returns the following cycle.
- wr_ready=0 in every non-IDLE state. Back-to-back requests therefore need at least 1 IDLE cycle between them.
- busy = (state != IDLE).
- rom_we and rom_oe are never asserted simultaneously.
- dq_oe is never 1 while rom_oe=0.
- Minimum latency, accept to done: SETUP_CYC + PULSE_CYC + 1 + POLL_GAP + 1 cycles.

Test Plan:
- Basic write:
  - Stimulus: reset low for 3 cycles, release; write addr=13'h0010, data=32'h80FF7F01, be=4'hF; dq_in model returns the written data on the first poll.
  - Required: done at cycle 10 after accept with default parameters; rom_addr lane 2 = 15'h0042; exactly one rom_we low pulse of 4 cycles.
- Slow chip:
  - Stimulus: model returns inverted DQ7 for 3 polls, then correct data.
  - Required: 4 poll windows, done asserted, err never asserted.
- Timeout:
  - Stimulus: TIMEOUT=50; DQ7 never matches.
  - Required: err pulse exactly 50 cycles after POLL entry; done never asserted; wr_ready high the next cycle.
- Partial lanes:
  - Stimulus: be=4'b0101, data=32'h00800080; lanes 1 and 3 return garbage.
  - Required: rom_ce=4'b1010 during the write; done asserted.
- be=0 request:
  - Required: done one cycle after accept; rom_we and rom_ce stay high throughout.
- Reset mid-operation:
  - Stimulus: rst_flag low during PULSE.
  - Required: next edge gives rom_we=1, rom_ce=4'hF, dq_oe=0, no done/err; after release, a new request completes normally.
